// File: rtl/mem_pkg.sv
// Shared types for the data-memory port arbiter: owner tags, FSM states and
// the request bundle presented to the memory.
package mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_e;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU data port and the
// debug/loader port: CPU priority, bounded starvation of debug, debug lock.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CPU_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              dbg_locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(CPU_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_BURST_MAX);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  owner_e           tag_q, tag_d;
  logic             lock_active;
  port_req_t        sel_req;

  // Grants are gated by rst_n so nothing reaches the memory while in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    lock_active = dbg_lock || (state_q == LOCKED);
    if (rst_n) begin
      if (lock_active) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (run_cnt_q == CNT_MAX) dbg_gnt = 1'b1;
        else                      cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    if (cpu_gnt)      sel_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    else if (dbg_gnt) sel_req = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  end

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = sel_req.we;
  assign mem_addr  = sel_req.addr;
  assign mem_wdata = sel_req.wdata;

  always_comb begin
    state_d   = dbg_lock ? LOCKED : ARB;
    run_cnt_d = run_cnt_q;
    if (dbg_gnt || !dbg_req)           run_cnt_d = '0;
    else if (cpu_gnt && run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 1'b1;

    tag_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)      tag_d = OWN_CPU;
    else if (dbg_gnt && !dbg_we) tag_d = OWN_DBG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      run_cnt_q <= '0;
      tag_q     <= OWN_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      tag_q     <= tag_d;
    end
  end

  assign dbg_locked = (state_q == LOCKED);
  assign cpu_rvalid = (tag_q == OWN_CPU);
  assign dbg_rvalid = (tag_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: bench-side memory, a behavioural
// model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int BMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_locked;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory array outside the DUT; unread cycles return noise so rdata gating shows.
  logic [DW-1:0] bmem [4096];
  always @(posedge clk) begin
    if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr];
    else                   mem_rdata <= DW'($urandom);
  end

  // Behavioural model: expected grants from the arbitration rules, plus a shadow memory.
  logic [DW-1:0] shadow [4096];
  bit            m_locked;
  int            m_streak;
  int            m_rv;
  logic [DW-1:0] m_rv_data;

  always @(negedge clk) begin
    bit            lk, e_cpu, e_dbg, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    if (!rst_n) begin
      check("rst_cpu_gnt", cpu_gnt, 0);
      check("rst_dbg_gnt", dbg_gnt, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_dbg_rvalid", dbg_rvalid, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dbg_rdata", dbg_rdata, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_dbg_locked", dbg_locked, 0);
      m_locked = 0; m_streak = 0; m_rv = 0; m_rv_data = '0;
    end else begin
      lk = dbg_lock || m_locked;
      e_cpu = 0; e_dbg = 0;
      if (lk)                      e_dbg = dbg_req;
      else if (cpu_req && dbg_req) begin
        if (m_streak == BMAX) e_dbg = 1;
        else                  e_cpu = 1;
      end else begin
        e_cpu = cpu_req; e_dbg = dbg_req;
      end
      e_we = 0; e_addr = '0; e_wdata = '0;
      if (e_cpu)      begin e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
      else if (e_dbg) begin e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; end

      check("cpu_gnt", cpu_gnt, e_cpu);
      check("dbg_gnt", dbg_gnt, e_dbg);
      check("mem_en", mem_en, e_cpu | e_dbg);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("dbg_locked", dbg_locked, m_locked);
      check("cpu_rvalid", cpu_rvalid, m_rv == 1);
      check("dbg_rvalid", dbg_rvalid, m_rv == 2);
      check("cpu_rdata", cpu_rdata, (m_rv == 1) ? m_rv_data : '0);
      check("dbg_rdata", dbg_rdata, (m_rv == 2) ? m_rv_data : '0);

      if (e_dbg || !dbg_req) m_streak = 0;
      else if (e_cpu && m_streak < BMAX) m_streak++;
      m_locked = dbg_lock;
      m_rv = 0;
      if (e_cpu || e_dbg) begin
        if (e_we) shadow[e_addr] = e_wdata;
        else begin
          m_rv      = e_cpu ? 1 : 2;
          m_rv_data = shadow[e_addr];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cpu_pat, dbg_pat;
    for (int i = 0; i < 4096; i++) begin bmem[i] = '0; shadow[i] = '0; end
    rst_n = 1'b0; dbg_lock = 1'b0;
    cpu_set(1, 1, 12'h001, 16'h1111);
    dbg_set(1, 1, 12'h002, 16'h2222);
    @(negedge clk);
    check("lit_reset_cpu_gnt", cpu_gnt, 0);
    check("lit_reset_mem_en", mem_en, 0);
    tick();
    rst_n = 1'b1;
    cpu_set(0, 0, '0, '0); dbg_set(0, 0, '0, '0);
    tick();

    // CPU only: write then read back.
    cpu_set(1, 1, 12'h005, 16'h1234);
    @(negedge clk); check("lit_cpu_wr_gnt", cpu_gnt, 1);
    tick(); cpu_set(1, 0, 12'h005, 16'h0000);
    @(negedge clk); check("lit_cpu_rd_gnt", cpu_gnt, 1);
    check("lit_cpu_rd_no_rvalid_yet", cpu_rvalid, 0);
    tick(); cpu_set(0, 0, '0, '0);
    @(negedge clk);
    check("lit_cpu_rvalid", cpu_rvalid, 1);
    check("lit_cpu_rdata", cpu_rdata, 32'h1234);
    check("lit_cpu_dbg_idle", dbg_rvalid, 0);
    tick();

    // Contention: both held high, debug wins every ninth cycle.
    cpu_set(1, 1, 12'h100, 16'hAAAA);
    dbg_set(1, 0, 12'h005, 16'h0000);
    cpu_pat = '0; dbg_pat = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cpu_pat[i] = cpu_gnt;
      dbg_pat[i] = dbg_gnt;
      tick();
    end
    check("lit_contention_dbg_pattern", dbg_pat, 32'h0002_0100);
    check("lit_contention_cpu_pattern", cpu_pat, 32'h0001_FEFF);
    cpu_set(0, 0, '0, '0); dbg_set(0, 0, '0, '0);
    tick();

    // Lock mid CPU read stream; the read granted just before lock still returns.
    cpu_set(1, 0, 12'h005, 16'h0000);
    @(negedge clk); check("lit_pre_lock_cpu_gnt", cpu_gnt, 1);
    tick(); dbg_lock = 1'b1;
    @(negedge clk);
    check("lit_lock_same_cycle_cpu_gnt", cpu_gnt, 0);
    check("lit_lock_not_yet_locked", dbg_locked, 0);
    check("lit_straddle_cpu_rvalid", cpu_rvalid, 1);
    check("lit_straddle_cpu_rdata", cpu_rdata, 32'h1234);
    tick(); dbg_set(1, 1, 12'h7FF, 16'hBEEF);
    @(negedge clk);
    check("lit_locked", dbg_locked, 1);
    check("lit_locked_cpu_gnt", cpu_gnt, 0);
    check("lit_locked_dbg_wr_gnt", dbg_gnt, 1);
    tick(); dbg_set(1, 0, 12'h7FF, 16'h0000);
    @(negedge clk); check("lit_locked_dbg_rd_gnt", dbg_gnt, 1);
    tick(); dbg_set(0, 0, '0, '0);
    @(negedge clk);
    check("lit_dbg_rvalid", dbg_rvalid, 1);
    check("lit_dbg_rdata", dbg_rdata, 32'hBEEF);
    check("lit_dbg_read_cpu_rdata", cpu_rdata, 0);
    tick(); dbg_lock = 1'b0;
    @(negedge clk);
    check("lit_unlock_cycle_cpu_gnt", cpu_gnt, 0);
    tick();
    @(negedge clk);
    check("lit_after_unlock_cpu_gnt", cpu_gnt, 1);
    check("lit_after_unlock_locked", dbg_locked, 0);
    tick(); cpu_set(0, 0, '0, '0);
    tick();

    // Back-to-back mixed reads.
    cpu_set(1, 1, 12'h010, 16'h0A10);
    tick(); cpu_set(1, 1, 12'h020, 16'h0B20);
    tick(); cpu_set(1, 0, 12'h010, 16'h0000);
    tick(); cpu_set(0, 0, '0, '0); dbg_set(1, 0, 12'h020, 16'h0000);
    @(negedge clk);
    check("lit_mixed_cpu_rvalid", cpu_rvalid, 1);
    check("lit_mixed_cpu_rdata", cpu_rdata, 32'h0A10);
    check("lit_mixed_dbg_rdata_idle", dbg_rdata, 0);
    tick(); dbg_set(0, 0, '0, '0);
    @(negedge clk);
    check("lit_mixed_dbg_rvalid", dbg_rvalid, 1);
    check("lit_mixed_dbg_rdata", dbg_rdata, 32'h0B20);
    check("lit_mixed_cpu_rdata_idle", cpu_rdata, 0);
    tick();

    // Reset the cycle after a read grant: the return is discarded.
    cpu_set(1, 0, 12'h010, 16'h0000);
    @(negedge clk); check("lit_prereset_cpu_gnt", cpu_gnt, 1);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    check("lit_midreset_cpu_rvalid", cpu_rvalid, 0);
    check("lit_midreset_cpu_gnt", cpu_gnt, 0);
    tick(); rst_n = 1'b1; cpu_set(0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_postreset_no_rvalid", cpu_rvalid | dbg_rvalid, 0);
      tick();
    end
    check("lit_postreset_state_arb", dbg_locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
